// File: rtl/hk_spi_regbridge.sv
// SPI-to-housekeeping register bridge: synchronizes SPI write strobes, keeps a shadow
// register file for SPI readback and forwards every write to the back-end over req/ack.
module hk_spi_regbridge #(
    parameter int NREGS     = 32,
    parameter int TO_CYCLES = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic [7:0] spi_addr,
    input  logic [7:0] spi_wdata,
    input  logic       spi_wrstb,
    output logic [7:0] spi_rdata,
    output logic       bus_req,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    input  logic       bus_ack,
    input  logic       upd_valid,
    input  logic [7:0] upd_addr,
    input  logic [7:0] upd_data,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err,
    input  logic       err_clr
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CW = $clog2(TO_CYCLES);
    localparam logic [8:0]    NREGS_W = 9'(NREGS);
    localparam logic [CW-1:0] CNT_MAX = CW'(TO_CYCLES - 1);

    typedef enum logic {IDLE, REQ} state_e;

    state_e        state_q, state_d;
    logic [2:0]    sync_q;
    logic          cap;
    logic          spi_hit, upd_hit;
    logic [7:0]    shadow_q [NREGS];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
    logic [7:0]    skid_addr_q, skid_addr_d, skid_wdata_q, skid_wdata_d;
    logic          skid_full_q, skid_full_d;
    logic          ovr_q, to_q, ovr_set, to_set;

    // sync_q[1] is the synchronized strobe, sync_q[2] its delayed copy for edge detect
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) sync_q <= 3'b000;
        else            sync_q <= {sync_q[1:0], spi_wrstb};
    end
    assign cap = sync_q[1] & ~sync_q[2];

    assign spi_hit = {1'b0, spi_addr} < NREGS_W;
    assign upd_hit = {1'b0, upd_addr} < NREGS_W;

    // SPI write is issued last so it overrides a same-address hardware update
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            for (int i = 0; i < NREGS; i++) shadow_q[i] <= 8'h00;
        end else begin
            if (upd_valid && upd_hit) shadow_q[upd_addr[AW-1:0]] <= upd_data;
            if (cap && spi_hit)       shadow_q[spi_addr[AW-1:0]] <= spi_wdata;
        end
    end

    assign spi_rdata = spi_hit ? shadow_q[spi_addr[AW-1:0]] : 8'h00;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        skid_addr_d  = skid_addr_q;
        skid_wdata_d = skid_wdata_q;
        skid_full_d  = skid_full_q;
        ovr_set      = 1'b0;
        to_set       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cap) begin
                    state_d     = REQ;
                    bus_addr_d  = spi_addr;
                    bus_wdata_d = spi_wdata;
                    cnt_d       = '0;
                end
            end
            REQ: begin
                if (bus_ack || cnt_q == CNT_MAX) begin
                    // ack in the expiry cycle still counts as success
                    to_set = ~bus_ack;
                    cnt_d  = '0;
                    if (skid_full_q) begin
                        bus_addr_d  = skid_addr_q;
                        bus_wdata_d = skid_wdata_q;
                        skid_full_d = cap;
                        if (cap) begin
                            skid_addr_d  = spi_addr;
                            skid_wdata_d = spi_wdata;
                        end
                    end else if (cap) begin
                        bus_addr_d  = spi_addr;
                        bus_wdata_d = spi_wdata;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cap) begin
                        if (!skid_full_q) begin
                            skid_full_d  = 1'b1;
                            skid_addr_d  = spi_addr;
                            skid_wdata_d = spi_wdata;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bus_addr_q   <= 8'h00;
            bus_wdata_q  <= 8'h00;
            skid_addr_q  <= 8'h00;
            skid_wdata_q <= 8'h00;
            skid_full_q  <= 1'b0;
            ovr_q        <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            skid_addr_q  <= skid_addr_d;
            skid_wdata_q <= skid_wdata_d;
            skid_full_q  <= skid_full_d;
            ovr_q        <= ovr_set | (ovr_q & ~err_clr);
            to_q         <= to_set  | (to_q  & ~err_clr);
        end
    end

    assign bus_req     = (state_q == REQ);
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign busy        = (state_q == REQ) | skid_full_q;
    assign overrun     = ovr_q;
    assign timeout_err = to_q;
endmodule

// File: tb/tb_hk_spi_regbridge.sv
// Directed bench for hk_spi_regbridge: write path, timeout, skid/overrun, update priority,
// out-of-range addresses and reset during a transaction.
module tb_hk_spi_regbridge;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] spi_addr, spi_wdata, upd_addr, upd_data;
    logic       spi_wrstb, bus_ack, upd_valid, err_clr;
    logic [7:0] spi_rdata, bus_addr, bus_wdata;
    logic       bus_req, busy, overrun, timeout_err;

    int checks = 0;
    int errors = 0;
    int reqcnt = 0;
    logic [7:0] last_addr, last_wdata;

    hk_spi_regbridge #(.NREGS(32), .TO_CYCLES(64)) dut (
        .wb_clk_i(clk), .wb_rstn_i(rstn),
        .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wrstb(spi_wrstb),
        .spi_rdata(spi_rdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_data(upd_data),
        .busy(busy), .overrun(overrun), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // bus monitor: counts cycles with bus_req high and records the last request
    always @(posedge clk) begin
        if (bus_req) begin
            reqcnt     = reqcnt + 1;
            last_addr  = bus_addr;
            last_wdata = bus_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        spi_addr  = a;
        spi_wdata = d;
        spi_wrstb = 1'b1;
        repeat (4) tick();
        spi_wrstb = 1'b0;
        repeat (2) tick();
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        spi_addr = a;
        #1;
        chk(tag, {24'h0, spi_rdata}, {24'h0, exp});
    endtask

    initial begin
        rstn = 1'b0; spi_addr = 8'h00; spi_wdata = 8'h00; spi_wrstb = 1'b0;
        bus_ack = 1'b0; upd_valid = 1'b0; upd_addr = 8'h00; upd_data = 8'h00; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_bus_addr", {24'h0, bus_addr}, 32'h0);
        chk("rst_errs", {30'h0, overrun, timeout_err}, 32'h0);
        chk("rst_rdata", {24'h0, spi_rdata}, 32'h0);
        rstn = 1'b1;
        tick();

        // isolated write, ack tied high: exactly one request cycle
        bus_ack = 1'b1; reqcnt = 0;
        wr(8'h0A, 8'h5C);
        repeat (2) tick();
        chk("t1_reqcnt", reqcnt, 1);
        chk("t1_bus_addr", {24'h0, last_addr}, 32'h0A);
        chk("t1_bus_wdata", {24'h0, last_wdata}, 32'h5C);
        rd_chk("t1_rdata", 8'h0A, 8'h5C);

        // timeout: request held 64 cycles then aborted
        bus_ack = 1'b0; reqcnt = 0;
        wr(8'h07, 8'h33);
        repeat (70) tick();
        chk("t2_reqcnt", reqcnt, 64);
        chk("t2_timeout_err", {31'h0, timeout_err}, 32'h1);
        chk("t2_busy", {31'h0, busy}, 32'h0);
        chk("t2_overrun", {31'h0, overrun}, 32'h0);
        rd_chk("t2_rdata", 8'h07, 8'h33);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t2_clr", {31'h0, timeout_err}, 32'h0);

        // three back-to-back writes with no ack: bus, skid, dropped
        wr(8'h01, 8'h11);
        wr(8'h02, 8'h22);
        wr(8'h03, 8'h33);
        chk("t3_bus_addr", {24'h0, bus_addr}, 32'h01);
        chk("t3_bus_wdata", {24'h0, bus_wdata}, 32'h11);
        chk("t3_overrun", {31'h0, overrun}, 32'h1);
        chk("t3_busy", {31'h0, busy}, 32'h1);
        rd_chk("t3_sh1", 8'h01, 8'h11);
        rd_chk("t3_sh2", 8'h02, 8'h22);
        rd_chk("t3_sh3", 8'h03, 8'h33);
        bus_ack = 1'b1; tick();
        chk("t3_pop_req", {31'h0, bus_req}, 32'h1);
        chk("t3_pop_addr", {24'h0, bus_addr}, 32'h02);
        chk("t3_pop_wdata", {24'h0, bus_wdata}, 32'h22);
        tick();
        chk("t3_done_busy", {31'h0, busy}, 32'h0);
        chk("t3_done_req", {31'h0, bus_req}, 32'h0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("t3_clr", {31'h0, overrun}, 32'h0);

        // SPI capture and hardware update to the same address on the same edge
        spi_addr = 8'h05; spi_wdata = 8'hAA; spi_wrstb = 1'b1;
        repeat (2) tick();
        upd_valid = 1'b1; upd_addr = 8'h05; upd_data = 8'h55;
        tick();
        upd_valid = 1'b0;
        tick();
        spi_wrstb = 1'b0;
        repeat (2) tick();
        rd_chk("t4_sh5", 8'h05, 8'hAA);
        upd_valid = 1'b1; upd_addr = 8'h06; upd_data = 8'h11;
        tick();
        upd_valid = 1'b0;
        rd_chk("t4_sh6", 8'h06, 8'h11);

        // out-of-range address: readback zero, shadow untouched, still forwarded
        rd_chk("t5_rd_f0", 8'hF0, 8'h00);
        reqcnt = 0;
        wr(8'hF0, 8'h99);
        chk("t5_reqcnt", reqcnt, 1);
        chk("t5_bus_addr", {24'h0, last_addr}, 32'hF0);
        chk("t5_bus_wdata", {24'h0, last_wdata}, 32'h99);
        rd_chk("t5_rd_f0b", 8'hF0, 8'h00);
        rd_chk("t5_alias10", 8'h10, 8'h00);

        // reset with a request outstanding and the skid full
        bus_ack = 1'b0;
        wr(8'h01, 8'hA1);
        wr(8'h02, 8'hB2);
        chk("t6_pre_req", {31'h0, bus_req}, 32'h1);
        chk("t6_pre_busy", {31'h0, busy}, 32'h1);
        rstn = 1'b0;
        #1;
        chk("t6_rst_req", {31'h0, bus_req}, 32'h0);
        chk("t6_rst_busy", {31'h0, busy}, 32'h0);
        chk("t6_rst_addr", {24'h0, bus_addr}, 32'h0);
        rd_chk("t6_rst_sh2", 8'h02, 8'h00);
        tick();
        rstn = 1'b1;
        reqcnt = 0;
        repeat (10) tick();
        chk("t6_post_reqcnt", reqcnt, 0);
        chk("t6_post_busy", {31'h0, busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hk_spi_regbridge.md
Name: hk_spi_regbridge

Overview:
- Sits directly downstream of the housekeeping SPI slave and consumes its write strobe, address and write data.
- Brings SPI register writes from the SCK domain into the housekeeping system clock domain.
- Keeps an 8-bit shadow register file that drives read data back to the SPI slave.
- Forwards each SPI write to the housekeeping back-end over a req/ack handshake, with a one-entry skid buffer, a timeout, and sticky error flags.

Parameters:
NREGS, 32, number of shadow registers; valid addresses are 0..NREGS-1 (NREGS ≤ 256).
TO_CYCLES, 64, number of wb_clk_i cycles bus_req may wait for bus_ack before the transaction is aborted (≥ 2).

Ports:
wb_clk_i  input  1  system clock; the only clock.
wb_rstn_i  input  1  asynchronous reset, active-low.
spi_addr  input  8  register address from the SPI slave (SCK domain).
spi_wdata  input  8  write data from the SPI slave (SCK domain).
spi_wrstb  input  1  write strobe from the SPI slave (SCK domain, level pulse).
spi_rdata  output  8  read data to the SPI slave: shadow[spi_addr].
bus_req  output  1  back-end write request.
bus_addr  output  8  back-end write address; stable while bus_req=1.
bus_wdata  output  8  back-end write data; stable while bus_req=1.
bus_ack  input  1  back-end accept; completes the request in the cycle it is sampled high.
upd_valid  input  1  hardware status update to the shadow file.
upd_addr  input  8  address for upd_valid.
upd_data  input  8  data for upd_valid.
busy  output  1  high when a request is outstanding or the skid buffer is full.
overrun  output  1  sticky: an SPI write was dropped.
timeout_err  output  1  sticky: a request was aborted by timeout.
err_clr  input  1  synchronous clear of overrun and timeout_err.

Behaviour:
- Reset (wb_rstn_i=0, asynchronous): all shadow registers 8'h00, synchronizer flops 0, FSM IDLE, skid empty, timeout counter 0.
  - Outputs held at reset: bus_req=0, bus_addr=0, bus_wdata=0, busy=0, overrun=0, timeout_err=0, spi_rdata=8'h00.
  - Reset mid-transaction drops bus_req immediately; pending data is discarded.
- Strobe synchronizer and edge detect:
  - spi_wrstb passes through a 2-flop synchronizer, then a third flop for rising-edge detect.
  - Capture edge: the 3rd rising wb_clk_i edge at which spi_wrstb is sampled high.
  - On the capture edge, spi_addr and spi_wdata are sampled.
  - Usage contract: wb_clk_i ≥ 4× SCK, and spi_addr/spi_wdata stable from spi_wrstb rise to the capture edge.
  - A strobe that stays high produces exactly one capture.
- Shadow write:
  - On the capture edge, if spi_addr < NREGS, shadow[spi_addr] ← spi_wdata.
  - Every captured write is forwarded to the back-end regardless of address.
- Hardware update:
  - upd_valid=1 and upd_addr < NREGS writes shadow[upd_addr] on the same clock edge.
  - If an SPI capture targets the same address on the same edge, the SPI write wins and the update is lost.
  - Different addresses on the same edge: both writes take effect.
- spi_rdata:
  - Combinational: shadow[spi_addr] when spi_addr < NREGS, else 8'h00.
  - The SPI slave samples it asynchronously; the shadow is quasi-static in the SCK timescale.
- Forwarding FSM:
  - IDLE: capture → REQ, loading bus_addr/bus_wdata; bus_req=1 from the capture edge.
  - REQ, bus_ack=1: transaction completes.
    - Skid full → stay in REQ, load the skid contents, skid empties, counter 0.
    - Skid empty → IDLE, bus_req=0.
  - REQ, no ack: the counter increments each cycle.
    - When the counter reaches TO_CYCLES-1 with bus_ack=0: set timeout_err, drop the request, then pop the skid (if full) or go to IDLE.
    - bus_ack=1 in the expiry cycle counts as success; no error is set.
  - Capture while in REQ: goes into the skid if it is empty.
    - If the skid is full, the capture is dropped and overrun is set; the shadow is still updated.
    - Capture in the same cycle as an ack with the skid full: the skid pops into the bus and the new capture enters the skid; no overrun.
- busy = (state==REQ) | skid_full.
- err_clr:
  - Clears overrun and timeout_err on the next edge.
  - A set event in the same cycle wins over the clear.
- Latency: an isolated write with bus_ack tied high shows bus_req for exactly 1 cycle.

Test Plan:
- Reset, then spi_addr=8'h0A, spi_wdata=8'h5C, pulse spi_wrstb, bus_ack tied 1 → shadow[10]=8'h5C; spi_rdata=8'h5C with spi_addr=8'h0A; one bus_req cycle with bus_addr=8'h0A, bus_wdata=8'h5C.
- bus_ack held 0 with TO_CYCLES=64 → bus_req high for 64 cycles then drops; timeout_err=1, busy=0; err_clr pulse → timeout_err=0.
- Three back-to-back writes to addresses 1, 2, 3 with bus_ack held 0 → first on the bus, second in the skid, third dropped with overrun=1; shadow holds all three values.
- Same-edge capture and upd_valid to address 5 (SPI 8'hAA, update 8'h55) → shadow[5]=8'hAA. Then update 8'h11 to address 6 alone → spi_rdata=8'h11 at spi_addr=6.
- spi_addr=8'hF0 with NREGS=32 → spi_rdata=8'h00; a write there leaves the shadow unchanged but still forwards bus_addr=8'hF0.
- Assert wb_rstn_i low while bus_req=1 and the skid is full → all outputs return to reset values immediately; after release there is no residual request.
